mul_14_share_arb: RTL and testbench

Controller that time-shares one signed 14×14 multiplier instance (`en`-gated, registered product) among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block arbitrates, registers operands into the multiplier, and tracks in-flight operations with a tag pipeline matched to the multiplier latency. It returns each product to its originator with a one-cycle response pulse, and sits between the requester engines and the multiplier datapath.

---
 rtl/mul_share_pkg.sv | 21 ++
 rtl/mul_share_rr_arb.sv | 67 ++++++
 rtl/mul_14_share_arb.sv | 110 +++++++++++
 tb/tb_mul_14_share_arb.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// Shared types and constants for the time-shared 14x14 multiplier controller.
// Round-robin arbitration is selected at build time with MUL_SHARE_RR_EN.
package mul_share_pkg;

    localparam int OP_W     = 14;
    localparam int PROD_W   = 27;
    localparam int NREQ_MAX = 8;
    localparam int ID_W     = $clog2(NREQ_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mul_share_rr_arb.sv
// Single-grant arbiter for the shared multiplier. MUL_SHARE_RR_EN defined gives
// round-robin starting at a pointer; undefined gives fixed lowest-index priority.
module mul_share_rr_arb
    import mul_share_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            grant_en,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] gnt,
    output logic            gnt_vld,
    output logic [ID_W-1:0] gnt_id
);

`ifdef MUL_SHARE_RR_EN
    logic [ID_W-1:0] ptr_q, ptr_d;

    // Scan ranks k = 0..NREQ-1 away from the pointer; index i has rank k when
    // ptr+k wraps onto it. Constant indices keep the select lint-clean.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant_en && !gnt_vld && req_valid[i] &&
                    ((int'(ptr_q) + k == i) || (int'(ptr_q) + k == i + NREQ))) begin
                    gnt[i]  = 1'b1;
                    gnt_vld = 1'b1;
                    gnt_id  = ID_W'(i);
                end
            end
        end
        ptr_d = ptr_q;
        if (gnt_vld) begin
            ptr_d = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_en && !gnt_vld && req_valid[i]) begin
                gnt[i]  = 1'b1;
                gnt_vld = 1'b1;
                gnt_id  = ID_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/mul_14_share_arb.sv
// Time-shares one registered signed multiplier among NREQ requesters and routes
// each product back to its originator. Arbitration style set by MUL_SHARE_RR_EN.
module mul_14_share_arb
    import mul_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = OP_W,
    parameter int PW   = PROD_W,
    parameter int LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              mul_en,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [PW-1:0]     mul_p,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [PW-1:0]     rsp_p,
    output logic              idle
);

    state_e          state_q, state_d;
    tag_t            tag_q [LAT+1];
    logic            grant_en, issue, in_flight;
    logic            mul_en_q, mul_en_d;
    logic [NREQ-1:0] gnt;
    logic [ID_W-1:0] gnt_id;
    logic [W-1:0]    mul_a_q, mul_b_q, sel_a, sel_b;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [PW-1:0]   rsp_p_q;

    assign grant_en = (state_q == ST_RUN) && en;

    mul_share_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .grant_en  (grant_en),
        .req_valid (req_valid),
        .gnt       (gnt),
        .gnt_vld   (issue),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        in_flight = 1'b0;
        for (int k = 0; k <= LAT; k++) in_flight = in_flight | tag_q[k].valid;
        // Multiplier must be enabled in every cycle a tag occupies stages 0..LAT-1.
        mul_en_d = issue;
        for (int k = 0; k < LAT; k++) mul_en_d = mul_en_d | tag_q[k].valid;
        sel_a = mul_a_q;
        sel_b = mul_b_q;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid_d[i] = tag_q[LAT].valid && (tag_q[LAT].id == ID_W'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en) state_d = ST_RUN;
            ST_RUN:   if (!en) state_d = in_flight ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: begin
                if (en)              state_d = ST_RUN;
                else if (!in_flight) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mul_en_q    <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_valid_q <= '0;
            rsp_p_q     <= '0;
            for (int k = 0; k <= LAT; k++) tag_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            mul_en_q    <= mul_en_d;
            mul_a_q     <= sel_a;
            mul_b_q     <= sel_b;
            rsp_valid_q <= rsp_valid_d;
            if (tag_q[LAT].valid) rsp_p_q <= mul_p;
            tag_q[0] <= '{valid: issue, id: gnt_id};
            for (int k = 1; k <= LAT; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    assign req_ready = gnt;
    assign mul_en    = mul_en_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_p     = rsp_p_q;
    assign idle      = (state_q == ST_IDLE);

endmodule

// File: tb/tb_mul_14_share_arb.sv
// Directed bench for mul_14_share_arb with a 1-cycle enable-gated multiplier model.
// Contention scenario follows MUL_SHARE_RR_EN (round-robin vs fixed priority).
module tb_mul_14_share_arb;

    localparam int NREQ = 4;
    localparam int W    = 14;
    localparam int PW   = 27;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              mul_en;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [PW-1:0]     mul_p;
    logic [NREQ-1:0]   rsp_valid;
    logic [PW-1:0]     rsp_p;
    logic              idle;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mul_14_share_arb #(.NREQ(NREQ), .W(W), .PW(PW), .LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_en    (mul_en),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_p     (rsp_p),
        .idle      (idle)
    );

    // Behavioural multiplier: full signed product truncated to PW bits.
    logic signed [2*W-1:0] full_p;
    assign full_p = $signed(mul_a) * $signed(mul_b);
    initial mul_p = '0;
    always_ff @(posedge clk) begin
        if (mul_en) mul_p <= full_p[PW-1:0];
    end

    task automatic chk(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    // Assumes state RUN with en=1; issues one op on requester 0 and checks its response.
    task automatic corner(input string tag, input int a, input int b, input int exp);
        nx();
        req_valid = 4'b0001;
        set_op(0, a, b);
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(4'b0001));
        nx();
        req_valid = '0;
        nx();
        nx();
        #1;
        chk({tag, "_rspv"}, 32'(rsp_valid), 32'(4'b0001));
        chk({tag, "_rspp"}, $signed(rsp_p), exp);
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;

        nx();
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_mul_en", 32'(mul_en), 0);
        chk("rst_mul_a", 32'(mul_a), 0);
        chk("rst_rspv", 32'(rsp_valid), 0);
        chk("rst_rspp", 32'(rsp_p), 0);
        chk("rst_idle", 32'(idle), 1);
        nx();
        rst_n = 1'b1;

        // Single request: -3 * 7
        nx();
        en        = 1'b1;
        req_valid = 4'b0001;
        set_op(0, -3, 7);
        #1;
        chk("single_no_grant_idle", 32'(req_ready), 0);
        nx();
        #1;
        chk("single_ready", 32'(req_ready), 32'(4'b0001));
        nx();
        req_valid = '0;
        #1;
        chk("single_mul_en", 32'(mul_en), 1);
        chk("single_mul_a", $signed(mul_a), -3);
        chk("single_mul_b", $signed(mul_b), 7);
        chk("single_idle_busy", 32'(idle), 0);
        nx();
        #1;
        chk("single_rsp_early", 32'(rsp_valid), 0);
        nx();
        #1;
        chk("single_rspv", 32'(rsp_valid), 32'(4'b0001));
        chk("single_rspp", $signed(rsp_p), -21);
        nx();
        en = 1'b0;
        #1;
        chk("single_rsp_end", 32'(rsp_valid), 0);
        nx();
        #1;
        chk("single_idle_after", 32'(idle), 1);
        en = 1'b1;

        corner("c_min_min", -8192, -8192, -67108864);
        corner("c_max_min", 8191, -8192, -67100672);
        corner("c_zero_min", 0, -8192, 0);

        // Drain: three ops on requester 1, en drops on the following cycle
        nx();
        req_valid = 4'b0010;
        set_op(1, 2, -5);
        #1;
        chk("drain_ready0", 32'(req_ready), 32'(4'b0010));
        nx();
        set_op(1, 3, -5);
        nx();
        set_op(1, 4, -5);
        nx();
        en = 1'b0;
        #1;
        chk("drain_no_grant", 32'(req_ready), 0);
        chk("drain_rspv0", 32'(rsp_valid), 32'(4'b0010));
        chk("drain_rspp0", $signed(rsp_p), -10);
        nx();
        req_valid = '0;
        #1;
        chk("drain_rspp1", $signed(rsp_p), -15);
        chk("drain_idle1", 32'(idle), 0);
        nx();
        #1;
        chk("drain_rspv2", 32'(rsp_valid), 32'(4'b0010));
        chk("drain_rspp2", $signed(rsp_p), -20);
        chk("drain_idle2", 32'(idle), 0);
        nx();
        #1;
        chk("drain_idle3", 32'(idle), 1);
        chk("drain_rsp_end", 32'(rsp_valid), 0);

        // Reset one cycle after a grant
        en = 1'b1;
        nx();
        req_valid = 4'b0001;
        set_op(0, 5, 5);
        #1;
        chk("rmid_ready", 32'(req_ready), 32'(4'b0001));
        nx();
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        chk("rmid_mul_en", 32'(mul_en), 0);
        chk("rmid_mul_a", 32'(mul_a), 0);
        chk("rmid_idle", 32'(idle), 1);
        chk("rmid_ready0", 32'(req_ready), 0);
        chk("rmid_rspv", 32'(rsp_valid), 0);
        nx();
        rst_n = 1'b1;
        en    = 1'b0;
        for (int c = 0; c < 4; c++) begin
            nx();
            #1;
            chk("rmid_no_rsp", 32'(rsp_valid), 0);
        end

        // Contention
        en = 1'b1;
        nx();
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 10);
`ifdef MUL_SHARE_RR_EN
        req_valid = 4'b1111;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) nx();
            if (c == 8) req_valid = '0;
            #1;
            if (c < 8) chk("rr_grant", 32'(req_ready), 32'(1 << (c % 4)));
            if (c >= 3) begin
                chk("rr_rspv", 32'(rsp_valid), 32'(1 << ((c - 3) % 4)));
                chk("rr_rspp", $signed(rsp_p), ((c - 3) % 4 + 1) * 10);
            end
        end
`else
        req_valid = 4'b0101;
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) nx();
            if (c == 4) req_valid = 4'b0100;
            if (c == 5) req_valid = '0;
            #1;
            if (c < 4)  chk("fp_grant_low", 32'(req_ready), 32'(4'b0001));
            if (c == 4) chk("fp_grant_req2", 32'(req_ready), 32'(4'b0100));
            if (c >= 3 && c <= 6) begin
                chk("fp_rspv0", 32'(rsp_valid), 32'(4'b0001));
                chk("fp_rspp0", $signed(rsp_p), 10);
            end
            if (c == 7) begin
                chk("fp_rspv2", 32'(rsp_valid), 32'(4'b0100));
                chk("fp_rspp2", $signed(rsp_p), 30);
            end
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
